// File: rtl/ram_ctrl_pkg.sv
// Shared types and constants for the RAM burst controller and its read buffer.
package ram_ctrl_pkg;

   localparam int unsigned AW_DEF     = 5;
   localparam int unsigned DW_DEF     = 32;
   localparam int unsigned LW_DEF     = 6;

   localparam int unsigned FIFO_DEPTH = 2;
   localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WRITE = 3'd1,
      READ  = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } state_t;

endpackage

// File: rtl/rd_fifo2.sv
// Two-entry synchronous FIFO that buffers RAM read data toward the read stream.
module rd_fifo2
   import ram_ctrl_pkg::*;
#(
   parameter int unsigned DW = DW_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [DW-1:0]    din,
   input  logic             pop,
   output logic [CNT_W-1:0] count,
   output logic [DW-1:0]    head
);

   logic [DW-1:0] mem [FIFO_DEPTH];
   logic          wr_ptr;
   logic          rd_ptr;
   logic          push_ok;
   logic          pop_ok;

   // A push into a full buffer is only accepted when a pop frees a slot in the same cycle.
   assign pop_ok  = pop && (count != '0);
   assign push_ok = push && ((count != CNT_W'(FIFO_DEPTH)) || pop_ok);

   // Storage, pointers and occupancy.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            mem[i] <= '0;
         end
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop_ok) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Head word is presented directly from storage so it holds while not popped.
   assign head = mem[rd_ptr];

endmodule

// File: rtl/ram_burst_ctrl.sv
// Burst sequencer for a single-port RAM: turns one command into consecutive
// RAM accesses, fed by a write stream and draining into a buffered read stream.
module ram_burst_ctrl
   import ram_ctrl_pkg::*;
#(
   parameter int unsigned AW = AW_DEF,
   parameter int unsigned DW = DW_DEF,
   parameter int unsigned LW = LW_DEF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_wr,
   input  logic [AW-1:0] cmd_addr,
   input  logic [LW-1:0] cmd_len,
   input  logic          wr_valid,
   output logic          wr_ready,
   input  logic [DW-1:0] wr_data,
   output logic          rd_valid,
   input  logic          rd_ready,
   output logic [DW-1:0] rd_data,
   output logic          busy,
   output logic          done,
   output logic          cen,
   output logic          wen,
   output logic [AW-1:0] S_addr,
   output logic [DW-1:0] S_din,
   input  logic [DW-1:0] S_dout
);

   localparam int unsigned OCC_W = CNT_W + 1;

   state_t           state;
   state_t           state_nxt;
   logic [AW-1:0]    addr;
   logic [LW-1:0]    rem;
   logic             inflight;

   logic             load;
   logic             wr_fire;
   logic             issue;
   logic             pop;
   logic [CNT_W-1:0] fifo_count;
   logic [DW-1:0]    fifo_head;
   logic [OCC_W-1:0] occ;
   logic [OCC_W-1:0] cap;

   // Read stream view of the buffer.
   assign rd_valid = (fifo_count != '0);
   assign rd_data  = fifo_head;
   assign pop      = rd_valid && rd_ready;

   // Buffered plus in-flight words must fit; a same-cycle pop frees one slot,
   // which keeps one read per cycle flowing while the consumer is ready.
   assign occ = OCC_W'(fifo_count) + OCC_W'(inflight);
   assign cap = OCC_W'(FIFO_DEPTH) + OCC_W'(pop);

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state, handshakes and RAM strobes.
   always_comb begin
      state_nxt = state;
      cmd_ready = 1'b0;
      wr_ready  = 1'b0;
      busy      = (state != IDLE);
      done      = 1'b0;
      cen       = 1'b0;
      wen       = 1'b0;
      S_addr    = '0;
      S_din     = '0;
      load      = 1'b0;
      wr_fire   = 1'b0;
      issue     = 1'b0;

      case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               load = 1'b1;
               if (cmd_len == '0) begin
                  state_nxt = DONE;
               end else if (cmd_wr) begin
                  state_nxt = WRITE;
               end else begin
                  state_nxt = READ;
               end
            end
         end

         WRITE: begin
            wr_ready = 1'b1;
            if (wr_valid) begin
               wr_fire = 1'b1;
               cen     = 1'b1;
               wen     = 1'b1;
               S_addr  = addr;
               S_din   = wr_data;
               if (rem == LW'(1)) begin
                  state_nxt = DONE;
               end
            end
         end

         READ: begin
            if ((occ < cap) && (rem != '0)) begin
               issue  = 1'b1;
               cen    = 1'b1;
               S_addr = addr;
               if (rem == LW'(1)) begin
                  state_nxt = DRAIN;
               end
            end
         end

         DRAIN: begin
            if (!inflight && (fifo_count == '0)) begin
               state_nxt = DONE;
            end
         end

         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Burst address/length counters and read-in-flight flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr     <= '0;
         rem      <= '0;
         inflight <= 1'b0;
      end else begin
         inflight <= issue;
         if (load) begin
            addr <= cmd_addr;
            rem  <= cmd_len;
         end else if (wr_fire || issue) begin
            addr <= addr + AW'(1);
            rem  <= rem - LW'(1);
         end
      end
   end

   // RAM output is only valid the cycle after a read strobe, so it is pushed unconditionally then.
   rd_fifo2 #(
      .DW (DW)
   ) u_rd_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (inflight),
      .din   (S_dout),
      .pop   (pop),
      .count (fifo_count),
      .head  (fifo_head)
   );

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Directed bench for ram_burst_ctrl with a behavioural 32x32 registered-read RAM.
module tb_ram_burst_ctrl;

   logic        clk;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_wr;
   logic [4:0]  cmd_addr;
   logic [5:0]  cmd_len;
   logic        wr_valid;
   logic        wr_ready;
   logic [31:0] wr_data;
   logic        rd_valid;
   logic        rd_ready;
   logic [31:0] rd_data;
   logic        busy;
   logic        done;
   logic        cen;
   logic        wen;
   logic [4:0]  S_addr;
   logic [31:0] S_din;
   logic [31:0] S_dout;

   int n_checks = 0;
   int n_fail   = 0;

   ram_burst_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_wr    (cmd_wr),
      .cmd_addr  (cmd_addr),
      .cmd_len   (cmd_len),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .wr_data   (wr_data),
      .rd_valid  (rd_valid),
      .rd_ready  (rd_ready),
      .rd_data   (rd_data),
      .busy      (busy),
      .done      (done),
      .cen       (cen),
      .wen       (wen),
      .S_addr    (S_addr),
      .S_din     (S_din),
      .S_dout    (S_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM model plus a log of every write and a count of every read strobe.
   logic [31:0] ram [32];
   logic [4:0]  wa [256];
   logic [31:0] wd [256];
   int          wcount     = 0;
   int          n_rd_issue = 0;
   int          cen_cnt    = 0;
   int          done_cnt   = 0;

   always @(posedge clk) begin
      if (cen === 1'b1) begin
         if (wen === 1'b1) begin
            ram[S_addr] <= S_din;
            wa[wcount]  <= S_addr;
            wd[wcount]  <= S_din;
            wcount      <= wcount + 1;
            S_dout      <= 32'h0;
         end else begin
            S_dout     <= ram[S_addr];
            n_rd_issue <= n_rd_issue + 1;
         end
      end else begin
         S_dout <= 32'h0;
      end
   end

   always @(negedge clk) begin
      if (cen === 1'b1) cen_cnt <= cen_cnt + 1;
      if (done === 1'b1) done_cnt <= done_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer one command in IDLE; returns at the start of the first burst cycle.
   task automatic send_cmd(input logic wr, input logic [4:0] a, input logic [5:0] len);
      cmd_valid = 1'b1;
      cmd_wr    = wr;
      cmd_addr  = a;
      cmd_len   = len;
      @(negedge clk);
      check("cmd_ready", 32'(cmd_ready), 32'd1);
      step();
      cmd_valid = 1'b0;
   endtask

   // Write burst of consecutive values base, base+1, ... with no bubbles.
   task automatic write_burst(input logic [4:0] a, input int n, input logic [31:0] base);
      send_cmd(1'b1, a, 6'(n));
      for (int i = 0; i < n; i++) begin
         wr_valid = 1'b1;
         wr_data  = base + 32'(i);
         step();
      end
      wr_valid = 1'b0;
      step();
   endtask

   // Read-stream collector, stalling rd_ready for the first 'stall' cycles.
   logic [31:0] rx [16];
   int          rx_n;
   int          first_vld;
   int          issues_stalled;
   logic        done_seen;
   logic        hold_bad;

   task automatic collect(input int stall, input int max_cyc, input logic [31:0] hold_exp);
      int base_iss;
      base_iss       = n_rd_issue;
      rx_n           = 0;
      first_vld      = -1;
      issues_stalled = 0;
      done_seen      = 1'b0;
      hold_bad       = 1'b0;
      for (int cyc = 0; cyc < max_cyc && !done_seen; cyc++) begin
         rd_ready = (cyc >= stall);
         @(negedge clk);
         if (cyc == stall) issues_stalled = n_rd_issue - base_iss;
         if (rd_valid && first_vld < 0) first_vld = cyc;
         if (rd_valid && !rd_ready && rd_data !== hold_exp) hold_bad = 1'b1;
         if (rd_valid && rd_ready && rx_n < 16) begin
            rx[rx_n] = rd_data;
            rx_n++;
         end
         if (done) done_seen = 1'b1;
         step();
      end
      check("rd_burst_done", 32'(done_seen), 32'd1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   initial begin
      int base_w;
      int base_c;
      int base_d;
      logic [4:0] vpat;

      reset     = 1'b1;
      cmd_valid = 1'b0;
      cmd_wr    = 1'b0;
      cmd_addr  = '0;
      cmd_len   = '0;
      wr_valid  = 1'b0;
      wr_data   = '0;
      rd_ready  = 1'b0;

      // Reset values.
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("rst_busy",      32'(busy),      32'd0);
      check("rst_done",      32'(done),      32'd0);
      check("rst_rd_valid",  32'(rd_valid),  32'd0);
      check("rst_wr_ready",  32'(wr_ready),  32'd0);
      check("rst_cen_wen",   32'({cen, wen}), 32'd0);
      check("rst_S_addr",    32'(S_addr),    32'd0);
      check("rst_S_din",     S_din,          32'd0);
      step();
      reset = 1'b0;
      step();

      // Write burst addr 4, len 3, data A/B/C back-to-back.
      send_cmd(1'b1, 5'd4, 6'd3);
      for (int i = 0; i < 3; i++) begin
         wr_valid = 1'b1;
         wr_data  = 32'hA + 32'(i);
         @(negedge clk);
         check("wr_ready",  32'(wr_ready), 32'd1);
         check("wr_strobe", 32'({cen, wen}), 32'd3);
         check("wr_addr",   32'(S_addr), 32'd4 + 32'(i));
         check("wr_din",    S_din, 32'hA + 32'(i));
         step();
      end
      wr_valid = 1'b0;
      @(negedge clk);
      check("wr_done", 32'(done), 32'd1);
      check("wr_done_cen", 32'(cen), 32'd0);
      step();
      @(negedge clk);
      check("wr_done_pulse", 32'(done), 32'd0);
      check("wr_idle_ready", 32'(cmd_ready), 32'd1);
      step();

      // Read back addr 4, len 3.
      send_cmd(1'b0, 5'd4, 6'd3);
      collect(0, 40, 32'h0);
      check("rd_latency", 32'(first_vld), 32'd2);
      check("rd_count",   32'(rx_n), 32'd3);
      for (int i = 0; i < 3; i++) check("rd_word", rx[i], 32'hA + 32'(i));

      // Read backpressure: mem[0..3] = 1..4, stall 5 cycles.
      write_burst(5'd0, 4, 32'd1);
      send_cmd(1'b0, 5'd0, 6'd4);
      collect(5, 60, 32'd1);
      check("bp_issues_stalled", 32'(issues_stalled), 32'd2);
      check("bp_hold",           32'(hold_bad), 32'd0);
      check("bp_latency",        32'(first_vld), 32'd2);
      check("bp_count",          32'(rx_n), 32'd4);
      for (int i = 0; i < 4; i++) check("bp_word", rx[i], 32'd1 + 32'(i));
      rd_ready = 1'b0;

      // Wrap-around write at 30, then readback.
      base_w = wcount;
      write_burst(5'd30, 4, 32'h11);
      check("wrap_nwrites", 32'(wcount - base_w), 32'd4);
      check("wrap_a0", 32'(wa[base_w]),     32'd30);
      check("wrap_a1", 32'(wa[base_w + 1]), 32'd31);
      check("wrap_a2", 32'(wa[base_w + 2]), 32'd0);
      check("wrap_a3", 32'(wa[base_w + 3]), 32'd1);
      send_cmd(1'b0, 5'd30, 6'd4);
      collect(0, 40, 32'h0);
      check("wrap_rd_count", 32'(rx_n), 32'd4);
      for (int i = 0; i < 4; i++) check("wrap_rd_word", rx[i], 32'h11 + 32'(i));
      rd_ready = 1'b0;

      // Zero-length commands, both directions.
      for (int d = 0; d < 2; d++) begin
         base_c = cen_cnt;
         send_cmd(d[0], 5'd7, 6'd0);
         @(negedge clk);
         check("zl_done", 32'(done), 32'd1);
         step();
         @(negedge clk);
         check("zl_done_pulse", 32'(done), 32'd0);
         check("zl_cmd_ready",  32'(cmd_ready), 32'd1);
         step();
         check("zl_no_cen", 32'(cen_cnt - base_c), 32'd0);
      end

      // Write bubbles: wr_valid 1,0,1,0,1 with len 3.
      base_w = wcount;
      vpat   = 5'b10101;
      send_cmd(1'b1, 5'd10, 6'd3);
      for (int i = 0; i < 5; i++) begin
         wr_valid = vpat[i];
         wr_data  = 32'h100 + 32'(i);
         @(negedge clk);
         check("bub_cen", 32'(cen), 32'(vpat[i]));
         step();
      end
      wr_valid = 1'b0;
      @(negedge clk);
      check("bub_done", 32'(done), 32'd1);
      step();
      check("bub_nwrites", 32'(wcount - base_w), 32'd3);
      for (int i = 0; i < 3; i++) begin
         check("bub_addr", 32'(wa[base_w + i]), 32'd10 + 32'(i));
         check("bub_data", wd[base_w + i], 32'h100 + 32'(2 * i));
      end

      // Reset mid-read with two words buffered.
      send_cmd(1'b0, 5'd0, 6'd4);
      rd_ready = 1'b0;
      repeat (3) step();
      #1;
      check("mid_pre_rd_valid", 32'(rd_valid), 32'd1);
      check("mid_pre_busy",     32'(busy), 32'd1);
      reset = 1'b1;
      #1;
      check("mid_rst_rd_valid", 32'(rd_valid), 32'd0);
      check("mid_rst_busy",     32'(busy), 32'd0);
      check("mid_rst_cen",      32'(cen), 32'd0);
      step();
      reset  = 1'b0;
      base_d = done_cnt;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("mid_cmd_ready", 32'(cmd_ready), 32'd1);
         step();
      end
      check("mid_no_done", 32'(done_cnt - base_d), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
